// File: rtl/spi_frame_sniffer.sv
// spi_frame_sniffer: passive SPI monitor that captures full-duplex bytes into a FWFT FIFO and counts frames
//   in : clk, rst (async, active high), spi_clk/spi_ss/spi_mosi/spi_miso (async SPI pins),
//        rd_en (pop head), clr_overflow (clear sticky overflow)
//   out: rd_data {sof, mosi, miso}, empty, full, overflow, frame_active, frame_count
module spi_frame_sniffer #(
  parameter int FIFO_DEPTH  = 16,
  parameter bit CPHA        = 1'b1,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   spi_clk,
  input  logic                   spi_ss,
  input  logic                   spi_mosi,
  input  logic                   spi_miso,
  input  logic                   rd_en,
  input  logic                   clr_overflow,
  output logic [16:0]            rd_data,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow,
  output logic                   frame_active,
  output logic [FRAME_CNT_W-1:0] frame_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic {IDLE, ACTIVE} state_t;
  logic [2:0] sck_q, ss_q;
  logic [1:0] mosi_q, miso_q, vld_q;
  logic armed_q;
  state_t state_q;
  logic [2:0] bit_cnt_q;
  logic first_q, seen_q, push_q;
  logic [7:0] mosi_sr_q, miso_sr_q;
  logic [16:0] push_data_q;
  logic [FRAME_CNT_W-1:0] frame_count_q;
  logic [16:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q, cnt_d;
  logic empty_q, full_q, overflow_q;
  logic sample, ss_fall, ss_rise, byte_done, do_push, do_pop, drop;
  assign sample    = CPHA ? (sck_q[2] & ~sck_q[1]) : (~sck_q[2] & sck_q[1]);
  // a falling SS only counts once a genuine high level has been seen since reset,
  // so a frame already in progress at reset release is ignored
  assign ss_fall   = armed_q & ss_q[2] & ~ss_q[1];
  assign ss_rise   = ~ss_q[2] & ss_q[1];
  assign byte_done = sample & (bit_cnt_q == 3'd7);
  assign do_pop    = rd_en & ~empty_q;
  assign do_push   = push_q & (~full_q | rd_en);
  assign drop      = push_q & full_q & ~rd_en;
  assign cnt_d     = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  assign rd_data      = empty_q ? 17'd0 : mem_q[rd_q];
  assign empty        = empty_q;
  assign full         = full_q;
  assign overflow     = overflow_q;
  assign frame_active = (state_q == ACTIVE);
  assign frame_count  = frame_count_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_q   <= 3'b000;
      ss_q    <= 3'b111;
      mosi_q  <= 2'b00;
      miso_q  <= 2'b00;
      vld_q   <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      sck_q   <= {sck_q[1:0], spi_clk};
      ss_q    <= {ss_q[1:0], spi_ss};
      mosi_q  <= {mosi_q[0], spi_mosi};
      miso_q  <= {miso_q[0], spi_miso};
      vld_q   <= {vld_q[0], 1'b1};
      armed_q <= armed_q | (vld_q[1] & ss_q[1]);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      bit_cnt_q     <= 3'd0;
      first_q       <= 1'b1;
      seen_q        <= 1'b0;
      mosi_sr_q     <= 8'd0;
      miso_sr_q     <= 8'd0;
      push_q        <= 1'b0;
      push_data_q   <= 17'd0;
      frame_count_q <= '0;
    end else begin
      push_q <= 1'b0;
      if (state_q == IDLE) begin
        if (ss_fall) begin
          state_q   <= ACTIVE;
          bit_cnt_q <= 3'd0;
          first_q   <= 1'b1;
        end
      end else begin
        if (sample) begin
          mosi_sr_q <= {mosi_sr_q[6:0], mosi_q[1]};
          miso_sr_q <= {miso_sr_q[6:0], miso_q[1]};
          bit_cnt_q <= bit_cnt_q + 3'd1;
        end
        if (byte_done) begin
          push_q      <= 1'b1;
          push_data_q <= {first_q, mosi_sr_q[6:0], mosi_q[1], miso_sr_q[6:0], miso_q[1]};
          first_q     <= 1'b0;
          seen_q      <= 1'b1;
        end
        // a byte completing on the closing cycle still counts toward this frame
        if (ss_rise) begin
          state_q <= IDLE;
          seen_q  <= 1'b0;
          if (seen_q | byte_done) frame_count_q <= frame_count_q + 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_q       <= do_push ? wr_q + 1'b1 : wr_q;
      rd_q       <= do_pop ? rd_q + 1'b1 : rd_q;
      cnt_q      <= cnt_d;
      empty_q    <= (cnt_d == '0);
      full_q     <= (cnt_d == (AW+1)'(FIFO_DEPTH));
      overflow_q <= drop | (overflow_q & ~clr_overflow);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data_q;
  end
endmodule

// File: tb/tb_spi_frame_sniffer.sv
// tb_spi_frame_sniffer: randomized and directed checks of spi_frame_sniffer against a queue-based byte model
module tb_spi_frame_sniffer;
  localparam int DEPTH = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic sck = 1'b0, ss = 1'b1, mosi = 1'b0, miso = 1'b0, sel = 1'b0;
  logic rd_en = 1'b0, clr_ovf = 1'b0;
  logic [16:0] rd_data, rd_data1;
  logic empty, full, ovf, fa, empty1, full1, ovf1, fa1;
  logic [15:0] fc, fc1;
  int checks = 0, failures = 0;
  logic [16:0] q[$];
  int exp_fc = 0;
  logic exp_ovf = 1'b0;
  logic [7:0] tx_mo[32], tx_mi[32];
  always #5 clk = ~clk;
  spi_frame_sniffer #(.FIFO_DEPTH(DEPTH), .CPHA(1'b1), .FRAME_CNT_W(16)) dut (
    .clk(clk), .rst(rst), .spi_clk(sel ? 1'b0 : sck), .spi_ss(sel | ss),
    .spi_mosi(mosi), .spi_miso(miso), .rd_en(rd_en), .clr_overflow(clr_ovf),
    .rd_data(rd_data), .empty(empty), .full(full), .overflow(ovf),
    .frame_active(fa), .frame_count(fc)
  );
  spi_frame_sniffer #(.FIFO_DEPTH(DEPTH), .CPHA(1'b0), .FRAME_CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .spi_clk(sel & sck), .spi_ss(~sel | ss),
    .spi_mosi(mosi), .spi_miso(miso), .rd_en(1'b0), .clr_overflow(1'b0),
    .rd_data(rd_data1), .empty(empty1), .full(full1), .overflow(ovf1),
    .frame_active(fa1), .frame_count(fc1)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic model_push(input logic [16:0] e);
    if (q.size() >= DEPTH) exp_ovf = 1'b1;
    else q.push_back(e);
  endtask
  task automatic send_bits(input logic [7:0] mo, input logic [7:0] mi, input int nb, input bit popend);
    for (int i = 0; i < nb; i++) begin
      if (!sel) begin
        sck = 1'b1; mosi = mo[7-i]; miso = mi[7-i];
        repeat (4) @(negedge clk);
        sck = 1'b0;
        if (popend && i == nb - 1) begin
          repeat (3) @(negedge clk);
          chk("pop_on_full", rd_data, q.pop_front());
          rd_en = 1'b1;
          @(negedge clk);
          rd_en = 1'b0;
        end else repeat (4) @(negedge clk);
      end else begin
        mosi = mo[7-i]; miso = mi[7-i];
        repeat (4) @(negedge clk);
        sck = 1'b1;
        repeat (4) @(negedge clk);
        sck = 1'b0;
      end
    end
  endtask
  task automatic frame(input int n, input int extra, input int popat);
    ss = 1'b0;
    repeat (4) @(negedge clk);
    for (int b = 0; b < n; b++) begin
      send_bits(tx_mo[b], tx_mi[b], 8, b == popat);
      if (!sel) model_push({b == 0, tx_mo[b], tx_mi[b]});
    end
    if (extra > 0) send_bits(8'($urandom), 8'($urandom), extra, 1'b0);
    repeat (4) @(negedge clk);
    ss = 1'b1;
    repeat (8) @(negedge clk);
    if (!sel && n > 0) exp_fc++;
  endtask
  task automatic post_chk();
    chk("frame_count", fc, exp_fc);
    chk("overflow", ovf, exp_ovf);
    chk("frame_active_idle", fa, 0);
    chk("full", full, q.size() == DEPTH);
  endtask
  task automatic drain();
    while (q.size() > 0) begin
      chk("not_empty", empty, 0);
      chk("rd_data", rd_data, q.pop_front());
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
    end
    chk("empty", empty, 1);
    chk("rd_data_empty", rd_data, 0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_fa", fa, 0);
    chk("rst_fc", fc, 0);
    chk("rst_rd_data", rd_data, 0);
    repeat (4) @(negedge clk);
    tx_mo[0] = 8'h01; tx_mo[1] = 8'h00; tx_mo[2] = 8'h05;
    tx_mi[0] = 8'h02; tx_mi[1] = 8'h00; tx_mi[2] = 8'h00;
    frame(3, 0, -1);
    post_chk();
    chk("plan_e0", q[0], 17'h10102);
    chk("plan_e2", q[2], 17'h00500);
    drain();
    tx_mo[0] = 8'hC3; tx_mi[0] = 8'h9E;
    frame(1, 4, -1);
    post_chk();
    drain();
    ss = 1'b0;
    repeat (6) @(negedge clk);
    chk("pulse_fa_hi", fa, 1);
    ss = 1'b1;
    repeat (6) @(negedge clk);
    chk("pulse_fa_lo", fa, 0);
    post_chk();
    chk("pulse_empty", empty, 1);
    for (int f = 0; f < 8; f++) begin
      int n;
      n = $urandom_range(0, 4);
      for (int b = 0; b < n; b++) begin
        tx_mo[b] = 8'($urandom);
        tx_mi[b] = 8'($urandom);
      end
      frame(n, $urandom_range(0, 7), -1);
      post_chk();
      drain();
    end
    for (int b = 0; b < 17; b++) begin
      tx_mo[b] = 8'($urandom);
      tx_mi[b] = 8'($urandom);
    end
    frame(17, 0, -1);
    post_chk();
    chk("ovf_set", ovf, 1);
    chk("full_set", full, 1);
    drain();
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    exp_ovf = 1'b0;
    chk("ovf_clr", ovf, 0);
    frame(17, 0, 16);
    post_chk();
    chk("full_after_pop", full, 1);
    drain();
    ss = 1'b0;
    repeat (4) @(negedge clk);
    send_bits(8'hFF, 8'hFF, 5, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    q.delete();
    exp_fc = 0;
    exp_ovf = 1'b0;
    send_bits(8'h5A, 8'hA5, 8, 1'b0);
    repeat (6) @(negedge clk);
    chk("rst_mid_empty", empty, 1);
    chk("rst_mid_fa", fa, 0);
    ss = 1'b1;
    repeat (8) @(negedge clk);
    post_chk();
    tx_mo[0] = 8'h77; tx_mi[0] = 8'h11;
    frame(1, 0, -1);
    post_chk();
    drain();
    sel = 1'b1;
    repeat (4) @(negedge clk);
    tx_mo[0] = 8'hA5; tx_mi[0] = 8'h3C;
    frame(1, 0, -1);
    chk("cpha0_entry", rd_data1, 17'h1A53C);
    chk("cpha0_fc", fc1, 1);
    chk("cpha0_ovf", ovf1, 0);
    sel = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
